// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one Booth multiplier among NREQ requesters.
// Optional watchdog on the multiplier wait: define BOOTH_ARB_WATCHDOG_EN.
module booth_mul_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_m,
    input  logic [NREQ*WIDTH-1:0]   req_q,
    output logic [NREQ-1:0]         gnt,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_prod,
    output logic                    rsp_err,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_m,
    output logic [WIDTH-1:0]        mul_q,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_prod
);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d, cur_id, win_idx;
    logic [WIDTH-1:0] win_m, win_q;
    logic             any_req;
    logic             wd_fire;

    // First set request at or after ptr_q, wrapping around.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        any_req = 1'b0;
        win_idx = '0;
        win_m   = '0;
        win_q   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                win_idx = IDW'(idx);
                win_m   = req_m[idx*WIDTH +: WIDTH];
                win_q   = req_q[idx*WIDTH +: WIDTH];
            end
        end
        if (32'(win_idx) == NREQ - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_idx + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StLaunch;
            StLaunch: state_d = StWait;  // done ignored: may be a stale level
            StWait:   if (mul_done || wd_fire) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Decoded from state so an asynchronous reset clears them at once.
    always_comb begin
        gnt = '0;
        if (state_q == StLaunch) gnt[cur_id] = 1'b1;
        mul_start = (state_q == StLaunch);
        rsp_valid = (state_q == StResp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cur_id   <= '0;
            mul_m    <= '0;
            mul_q    <= '0;
            rsp_id   <= '0;
            rsp_prod <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && any_req) begin
                ptr_q  <= ptr_d;
                cur_id <= win_idx;
                mul_m  <= win_m;
                mul_q  <= win_q;
            end
            if (state_q == StWait) begin
                if (mul_done) begin
                    rsp_prod <= mul_prod;
                    rsp_id   <= cur_id;
                end else if (wd_fire) begin
                    rsp_prod <= '0;
                    rsp_id   <= cur_id;
                end
            end
        end
    end

`ifdef BOOTH_ARB_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(4 * WIDTH + 1);

    logic [WDW-1:0] wd_cnt;

    // Expires on the last of 4*WIDTH WAIT cycles without a done.
    assign wd_fire = (state_q == StWait) && !mul_done && (wd_cnt == WDW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state_q == StLaunch) begin
                wd_cnt <= WDW'(4 * WIDTH);
            end else if (state_q == StWait && wd_cnt != '0) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
            if (state_q == StWait) begin
                if (mul_done) begin
                    rsp_err <= 1'b0;
                end else if (wd_fire) begin
                    rsp_err <= 1'b1;
                end
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule
